prog_loader: RTL and testbench

- Copies a program image from the boot ROM into the processor's instruction memory when the load button (BTN[1]) is pressed.
- Sits between the board button inputs and ROM on one side, and the instruction-memory write port and core reset on the other, inside fpga_top.
- Holds the core in reset for the whole transfer, then flags completion on an LED.
- Runs on the PLL system clock, after s_reset has released.

---
 rtl/prog_loader.sv | 124 ++++++++++++
 tb/tb_prog_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot loader: on a debounced press of the load button, copies ROM_DEPTH words from the
// synchronous boot ROM into instruction memory, holding the core in reset while it runs.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for the first press since reset, core released
// S_LOAD  | issuing ROM reads, one address per cycle, core held
// S_DRAIN | last ROM word in flight, written this cycle
// S_DONE  | transfer finished, done set, core released, re-press reloads
module prog_loader #(
  parameter int ROM_DEPTH       = 256,
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 32,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_btn,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
);

  localparam int                DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(ROM_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic              r_sync1, r_sync2;
  logic              r_db_level, r_db_prev;
  logic [DB_W-1:0]   r_db_cnt;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_busy, r_cpu_hold, r_done;
  logic              w_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= start_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Level only flips after DEBOUNCE_CYCLES consecutive samples disagreeing with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_db_prev <= r_db_level;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_level <= ~r_db_level;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_start = r_db_level & ~r_db_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rd_ptr   <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state    <= S_LOAD;
            r_rd_ptr   <= '0;
            r_busy     <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        S_LOAD: begin
          // Address issued now is written next cycle, when its ROM data arrives.
          r_mem_we   <= 1'b1;
          r_mem_addr <= r_rd_ptr;
          r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
          if (r_rd_ptr == PTR_LAST) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_state    <= S_DONE;
          r_busy     <= 1'b0;
          r_cpu_hold <= 1'b0;
          r_done     <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom_addr  = r_rd_ptr;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  // ROM output register already aligns data with the registered write strobe.
  assign mem_wdata = r_mem_we ? rom_data : '0;
  assign busy      = r_busy;
  assign cpu_hold  = r_cpu_hold;
  assign done      = r_done;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: 256-word and 4-word instances, ROM models, write scoreboards.
module tb_prog_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int width;
    bit starts;
    bit done_after;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_btn = 1'b0;
  logic btn4 = 1'b0;

  logic [7:0]  rom_addr, mem_addr;
  logic [31:0] rom_data, mem_wdata;
  logic        mem_we, cpu_hold, busy, done;

  logic [1:0]  rom4_addr, mem4_addr;
  logic [31:0] rom4_data, mem4_wdata;
  logic        mem4_we, hold4, busy4, done4;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  wr_t exp_q[$];
  wr_t exp4_q[$];
  int  wr_count, first_wr, last_wr, busy_rise, done_rise, wr4_count;
  bit  busy_seen, prev_busy, prev_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  prog_loader #(.ROM_DEPTH(256), .ADDR_W(8), .DATA_W(32), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done));

  prog_loader #(.ROM_DEPTH(4), .ADDR_W(2), .DATA_W(32), .DEBOUNCE_CYCLES(8)) dut4 (
    .clk(clk), .reset(reset), .start_btn(btn4),
    .rom_addr(rom4_addr), .rom_data(rom4_data),
    .mem_we(mem4_we), .mem_addr(mem4_addr), .mem_wdata(mem4_wdata),
    .cpu_hold(hold4), .busy(busy4), .done(done4));

  always @(posedge clk) begin
    rom_data  <= 32'hA500_0000 | {24'h0, rom_addr};
    rom4_data <= 32'hB000_0000 | {30'h0, rom4_addr};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      wr_count++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (exp_q.size() == 0) chk("unexpected_write", {mem_we, mem_addr}, 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
      end
    end
    if (busy === 1'b1) begin
      busy_seen = 1'b1;
      if (!prev_busy) busy_rise = cyc;
      chk("hold_with_busy", cpu_hold, 1);
      chk("done_low_while_busy", done, 0);
    end
    if (done === 1'b1 && !prev_done) done_rise = cyc;
    prev_busy = (busy === 1'b1);
    prev_done = (done === 1'b1);
  end

  always @(negedge clk) begin
    wr_t e;
    if (mem4_we === 1'b1) begin
      wr4_count++;
      if (exp4_q.size() == 0) chk("small_unexpected_write", {mem4_we, mem4_addr}, 0);
      else begin
        e = exp4_q.pop_front();
        chk("small_wr_addr", mem4_addr, e.addr[1:0]);
        chk("small_wr_data", mem4_wdata, e.data);
      end
    end
  end

  task automatic arm();
    wr_count  = 0;
    first_wr  = -1;
    last_wr   = -1;
    busy_rise = -1;
    done_rise = -1;
    busy_seen = 1'b0;
  endtask

  task automatic push_full();
    wr_t e;
    for (int a = 0; a < 256; a++) begin
      e.addr = 8'(a);
      e.data = 32'hA500_0000 | 32'(a);
      exp_q.push_back(e);
    end
  endtask

  task automatic hold_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_transfer();
    int n = 0;
    while (done_rise < 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("transfer_timeout", done_rise < 0, 0);
    chk("wr_count", wr_count, 256);
    chk("first_wr_latency", 64'(first_wr - busy_rise), 1);
    chk("last_wr_latency", 64'(last_wr - busy_rise), 256);
    chk("done_latency", 64'(done_rise - busy_rise), 257);
    chk("busy_after", busy, 0);
    chk("hold_after", cpu_hold, 0);
    chk("done_after", done, 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  vec_t vecs[5];
  int   gw[3];

  initial begin
    int n;
    wr_t e;
    vecs[0] = '{3, 1'b0, 1'b0};
    vecs[1] = '{5, 1'b0, 1'b0};
    vecs[2] = '{7, 1'b0, 1'b0};
    vecs[3] = '{20, 1'b1, 1'b1};
    vecs[4] = '{6, 1'b0, 1'b1};
    gw[0] = 3; gw[1] = 5; gw[2] = 6;
    arm();
    prev_busy = 1'b0;
    prev_done = 1'b0;
    wr4_count = 0;

    hold_cycles(3);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    hold_cycles(5);

    // glitch rejection and a clean press, table driven
    for (int i = 0; i < 5; i++) begin
      arm();
      if (vecs[i].starts) push_full();
      start_btn = 1'b1;
      hold_cycles(vecs[i].width);
      start_btn = 1'b0;
      if (vecs[i].starts) expect_transfer();
      else begin
        hold_cycles(30);
        chk("glitch_no_start", busy_seen, 0);
        chk("glitch_no_write", wr_count, 0);
      end
      chk("vec_done_state", done, vecs[i].done_after);
      hold_cycles(15);
    end

    // bounce then stable press: one transfer, holding does not retrigger
    arm();
    push_full();
    for (int g = 0; g < 3; g++) begin
      start_btn = 1'b1;
      hold_cycles(gw[g]);
      start_btn = 1'b0;
      hold_cycles(10);
    end
    start_btn = 1'b1;
    expect_transfer();
    busy_seen = 1'b0;
    hold_cycles(50);
    chk("held_no_retrigger", busy_seen, 0);
    start_btn = 1'b0;
    hold_cycles(20);

    // re-press from DONE
    arm();
    push_full();
    start_btn = 1'b1;
    hold_cycles(20);
    start_btn = 1'b0;
    expect_transfer();
    hold_cycles(15);

    // release and re-press while loading
    arm();
    push_full();
    start_btn = 1'b1;
    n = 0;
    while (wr_count < 100 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_addr100_timeout", wr_count < 100, 0);
    start_btn = 1'b0;
    hold_cycles(15);
    start_btn = 1'b1;
    expect_transfer();
    busy_seen = 1'b0;
    hold_cycles(40);
    chk("repress_no_restart", busy_seen, 0);
    start_btn = 1'b0;
    hold_cycles(20);

    // reset in the middle of a load
    arm();
    push_full();
    start_btn = 1'b1;
    n = 0;
    while (!(mem_we === 1'b1 && mem_addr == 8'd50) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_addr50_timeout", n >= 500, 0);
    #1;
    reset = 1'b1;
    start_btn = 1'b0;
    #1;
    chk("abort_mem_we", mem_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hold", cpu_hold, 0);
    chk("abort_wdata", mem_wdata, 0);
    exp_q.delete();
    hold_cycles(3);
    reset = 1'b0;
    hold_cycles(10);
    chk("post_abort_idle", {busy, done, mem_we}, 0);
    arm();
    push_full();
    start_btn = 1'b1;
    hold_cycles(20);
    start_btn = 1'b0;
    expect_transfer();

    // small depth instance
    for (int a = 0; a < 4; a++) begin
      e.addr = 8'(a);
      e.data = 32'hB000_0000 | 32'(a);
      exp4_q.push_back(e);
    end
    wr4_count = 0;
    btn4 = 1'b1;
    hold_cycles(20);
    btn4 = 1'b0;
    n = 0;
    while (done4 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("small_done_timeout", done4 !== 1'b1, 0);
    hold_cycles(10);
    chk("small_wr_count", wr4_count, 4);
    chk("small_queue_drained", exp4_q.size(), 0);
    chk("small_busy_after", busy4, 0);
    chk("small_hold_after", hold4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
